// File: rtl/clkmeas.sv
// clkmeas: measures the period of an asynchronous clock/strobe (ckin) in
// local clock cycles, averaged over Average periods. Recovers the divide
// ratio of a divided or external clock (baud autodetect, clock sanity).
module clkmeas #(
  parameter int MaxPeriod = 65535,
  parameter int Average   = 4,
  localparam int Q = $clog2(MaxPeriod + 1),
  localparam int A = $clog2(Average)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         ckena,
  input  logic         ckin,
  output logic [Q-1:0] period,
  output logic         valid,
  output logic         stb,
  output logic         stale
);

  // index needs at least one bit even when Average = 1 (it then stays 0)
  localparam int NW = (A > 0) ? A : 1;
  localparam int AW = Q + A;
  localparam logic [Q-1:0]  MAXP  = Q'(MaxPeriod);
  localparam logic [NW-1:0] NLAST = NW'(Average - 1);

  generate
    if (MaxPeriod < 4) begin : g_bad_maxperiod
      $error("clkmeas: MaxPeriod must be >= 4");
    end
    if (Average < 1 || (Average & (Average - 1)) != 0) begin : g_bad_average
      $error("clkmeas: Average must be a power of two >= 1");
    end
  endgenerate

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state_q, state_d;
  logic            s1, s2, s3;
  logic            rise;
  logic [Q-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [NW-1:0]   n_q, n_d;
  logic [Q-1:0]    period_d;
  logic            valid_d, stb_d, stale_d;
  logic [AW-1:0]   sum;

  // Synchroniser plus edge flop; free-running so ckena never corrupts it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= ckin;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
  // running total including the period that is closing on this rise
  assign sum  = acc_q + AW'(cnt_q);

  // Next-state, counter/accumulator and output decode.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    n_d      = n_q;
    period_d = period;
    valid_d  = valid;
    stb_d    = 1'b0;
    stale_d  = 1'b0;
    if (ckena) begin
      if (rise)
        cnt_d = Q'(1);
      else if (cnt_q != MAXP)
        cnt_d = cnt_q + 1'b1;
      case (state_q)
        IDLE: begin
          if (rise) begin
            acc_d   = '0;
            n_d     = '0;
            state_d = RUN;
          end
        end
        RUN: begin
          // a rise on the saturation cycle is a legal MaxPeriod sample
          if (rise) begin
            if (n_q == NLAST) begin
              period_d = Q'(sum >> A);
              stb_d    = 1'b1;
              valid_d  = 1'b1;
              acc_d    = '0;
              n_d      = '0;
            end else begin
              acc_d = sum;
              n_d   = n_q + 1'b1;
            end
          end else if (cnt_q == MAXP) begin
            state_d  = IDLE;
            period_d = '0;
            valid_d  = 1'b0;
            stale_d  = valid;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Measurement state and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      n_q     <= '0;
      period  <= '0;
      valid   <= 1'b0;
      stb     <= 1'b0;
      stale   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      n_q     <= n_d;
      period  <= period_d;
      valid   <= valid_d;
      stb     <= stb_d;
      stale   <= stale_d;
    end
  end

endmodule

// File: tb/tb_clkmeas.sv
// tb_clkmeas: drives ckin as rising-edge gap sequences and checks clkmeas
// every cycle against a period-list model, plus literal spot checks.
module tb_clkmeas;
  localparam int MP = 5300;
  localparam int AV = 4;
  localparam int Q  = $clog2(MP + 1);

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         ckena = 1'b1;
  logic         ckin  = 1'b0;
  logic [Q-1:0] period;
  logic         valid, stb, stale;

  int n_chk = 0, n_fail = 0, stb_n = 0, stale_n = 0;

  // model state: ckin samples of the last three edges, measured periods
  bit h0 = 0, h1 = 0, h2 = 0, r;
  bit running = 0;
  int since = 0, msum;
  int plist[$];
  int e_period = 0, e_valid = 0, e_stb = 0, e_stale = 0;
  bit done;

  clkmeas #(.MaxPeriod(MP), .Average(AV)) dut (
    .clock (clock),
    .reset (reset),
    .ckena (ckena),
    .ckin  (ckin),
    .period(period),
    .valid (valid),
    .stb   (stb),
    .stale (stale)
  );

  always #5 clock = ~clock;

  task automatic cmp(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a rise is seen two edges after ckin is first sampled high; the
  // period is the number of enabled cycles between accepted rises.
  initial forever begin
    @(posedge clock or negedge reset);
    if (!reset) begin
      h0 = 0; h1 = 0; h2 = 0;
      running = 0; since = 0; plist.delete();
      e_period = 0; e_valid = 0; e_stb = 0; e_stale = 0;
    end else begin
      r  = h1 && !h2;
      h2 = h1; h1 = h0; h0 = ckin;
      e_stb = 0; e_stale = 0;
      if (ckena) begin
        if (r) begin
          if (running) begin
            plist.push_back(since + 1);
            if (plist.size() == AV) begin
              msum = 0;
              foreach (plist[i]) msum += plist[i];
              e_period = msum / AV;
              e_valid  = 1;
              e_stb    = 1;
              plist.delete();
            end
          end
          running = 1;
          since   = 0;
        end else if (running) begin
          if (since + 1 >= MP) begin
            running  = 0;
            e_stale  = e_valid;
            e_period = 0;
            e_valid  = 0;
            plist.delete();
          end else begin
            since++;
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clock);
    cmp("period", int'(period), e_period);
    cmp("valid",  int'(valid),  e_valid);
    cmp("stb",    int'(stb),    e_stb);
    cmp("stale",  int'(stale),  e_stale);
    if (stb)   stb_n++;
    if (stale) stale_n++;
  end

  // First rise now, then one rise after each gap; ends low, at a negedge.
  task automatic rise_seq(input int gaps[$]);
    ckin = 1'b1;
    foreach (gaps[i]) begin
      repeat (gaps[i] / 2) @(negedge clock);
      ckin = 1'b0;
      repeat (gaps[i] - gaps[i] / 2) @(negedge clock);
      ckin = 1'b1;
    end
    repeat (2) @(negedge clock);
    ckin = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic train(input int p, input int n);
    int q[$];
    for (int i = 0; i < n - 1; i++) q.push_back(p);
    rise_seq(q);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  initial begin
    int q[$];
    int s0, t0;
    #2 reset = 1'b0;
    @(negedge clock);
    cmp("rst_period", int'(period), 0);
    cmp("rst_valid",  int'(valid),  0);
    cmp("rst_stb",    int'(stb),    0);
    cmp("rst_stale",  int'(stale),  0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // 9600 baud at 50 MHz: first result on the 5th rise
    train(5208, 5);
    cmp("baud_period", int'(period), 5208);
    cmp("baud_valid",  int'(valid),  1);
    cmp("baud_stb_n",  stb_n,        1);
    // held low: timeout drops the result
    repeat (MP) @(negedge clock);
    cmp("to_stale_n", stale_n,      1);
    cmp("to_valid",   int'(valid),  0);
    cmp("to_period",  int'(period), 0);
    // restart needs Average+1 rises; last gap is 4 -> 604>>2
    train(200, 4);
    cmp("restart4_stb_n", stb_n, 1);
    train(200, 1);
    cmp("restart5_stb_n",  stb_n,        2);
    cmp("restart_period",  int'(period), 151);

    // alternating periods: 405 >> 2 = 101
    do_reset();
    s0 = stb_n;
    q = '{100, 102, 100, 103};
    rise_seq(q);
    cmp("alt_period", int'(period), 101);
    cmp("alt_stb_n",  stb_n - s0,   1);

    // minimum period 4: results on rises 5 and 9
    do_reset();
    s0 = stb_n;
    train(4, 9);
    cmp("min_period", int'(period), 4);
    cmp("min_stb_n",  stb_n - s0,   2);

    // period exactly MaxPeriod: rise on the saturation cycle is accepted
    do_reset();
    s0 = stb_n; t0 = stale_n;
    train(MP, 5);
    cmp("max_period",  int'(period), MP);
    cmp("max_valid",   int'(valid),  1);
    cmp("max_stale_n", stale_n - t0, 0);
    cmp("max_stb_n",   stb_n - s0,   1);

    // ckena low over the third rise: it is lost, later groups recover
    do_reset();
    s0 = stb_n;
    fork
      train(300, 14);
      begin
        repeat (590) @(negedge clock);
        ckena = 1'b0;
        repeat (50) @(negedge clock);
        ckena = 1'b1;
      end
    join
    cmp("ena_period", int'(period), 300);
    cmp("ena_stb_n",  stb_n - s0,   3);

    // asynchronous reset between edges while RUN with a valid result
    @(posedge clock);
    #3 reset = 1'b0;
    #1;
    cmp("areset_period", int'(period), 0);
    cmp("areset_valid",  int'(valid),  0);
    cmp("areset_stb",    int'(stb),    0);
    cmp("areset_stale",  int'(stale),  0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    s0 = stb_n;
    train(250, 5);
    cmp("cold_period", int'(period), 250);
    cmp("cold_stb_n",  stb_n - s0,   1);

    // random gaps with a random clock enable and one overlong gap
    do_reset();
    q.delete();
    for (int i = 0; i < 20; i++) q.push_back($urandom_range(4, 300));
    q[10] = MP + $urandom_range(1, 60);
    done = 0;
    fork
      begin
        rise_seq(q);
        done = 1;
      end
      begin
        while (!done) begin
          @(negedge clock);
          ckena = ($urandom_range(0, 7) != 0);
        end
      end
    join
    ckena = 1'b1;
    repeat (4) @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
